// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the control unit decode and instr_encoder.
package rv_isa_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // bit positions inside the one-hot instruction-class vector
  localparam int TYPE_R      = 0;
  localparam int TYPE_I      = 1;
  localparam int TYPE_LOAD   = 2;
  localparam int TYPE_STORE  = 3;
  localparam int TYPE_BRANCH = 4;
  localparam int TYPE_JAL    = 5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_BAD
  } instr_cls_e;

  // true when imm is representable as a signed value of the given width
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = $unsigned($signed(imm) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// 2-entry skid FIFO: 1-cycle fill latency, 1 word/cycle throughput; in_ready comes
// from registered occupancy only, so it drops only when both entries are held.
module enc_skid_buf #(
  parameter int               WIDTH   = 65,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       cnt;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = slot0;

  // slot0 is always the head; a pop shifts slot1 forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      slot0 <= RST_VAL;
      slot1 <= RST_VAL;
    end else if (clr) begin
      cnt   <= 2'd0;
      slot0 <= RST_VAL;
    end else begin
      case ({push, pop})
        2'b11: slot0 <= in_data;
        2'b10: begin
          if (cnt == 2'd0) slot0 <= in_data;
          else             slot1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs class + fields into an RV32I word with its byte address; 1-cycle latency, 2-entry skid.
// Build option ENC_IMM_CHECK_EN: out-of-range or misaligned immediates become an illegal NOP.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int WIDTH = 32 + ADDR_W + 1;

  instr_cls_e        cls;
  logic [31:0]       enc_instr;
  logic              imm_ok;
  logic              illegal;
  logic [31:0]       word;
  logic [ADDR_W-1:0] next_addr;
  logic [WIDTH-1:0]  buf_out;

  always_comb begin
    cls = CLS_BAD;
    case (in_type)
      6'b1 << TYPE_R:      cls = CLS_R;
      6'b1 << TYPE_I:      cls = CLS_I;
      6'b1 << TYPE_LOAD:   cls = CLS_LOAD;
      6'b1 << TYPE_STORE:  cls = CLS_STORE;
      6'b1 << TYPE_BRANCH: cls = CLS_BRANCH;
      6'b1 << TYPE_JAL:    cls = CLS_JAL;
      default:             cls = CLS_BAD;
    endcase
  end

  always_comb begin
    enc_instr = NOP;
    case (cls)
      CLS_R:      enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_R};
      CLS_I:      enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_I};
      CLS_LOAD:   enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
      CLS_STORE:  enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
      CLS_BRANCH: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], OPC_BRANCH};
      CLS_JAL:    enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, OPC_JAL};
      default:    enc_instr = NOP;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  always_comb begin
    imm_ok = 1'b1;
    case (cls)
      CLS_I, CLS_LOAD, CLS_STORE: imm_ok = imm_fits(in_imm, 12);
      CLS_BRANCH:                 imm_ok = imm_fits(in_imm, 13) && !in_imm[0];
      CLS_JAL:                    imm_ok = imm_fits(in_imm, 21) && !in_imm[0];
      default:                    imm_ok = 1'b1;
    endcase
  end
`else
  // high immediate bits are simply truncated in this build
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];
  assign imm_ok        = 1'b1;
`endif

  assign illegal = (cls == CLS_BAD) || !imm_ok;
  assign word    = illegal ? NOP : enc_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= BASE_ADDR;
    end else if (clr) begin
      next_addr <= BASE_ADDR;
    end else if (in_valid && in_ready) begin
      next_addr <= next_addr + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (clr) begin
      instr_count <= '0;
    end else if (out_valid && out_ready && (instr_count != '1)) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  enc_skid_buf #(
    .WIDTH  (WIDTH),
    .RST_VAL({32'h0, BASE_ADDR, 1'b0})
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({word, next_addr, illegal}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign {out_instr, out_addr, out_illegal} = buf_out;

endmodule
